alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 46 ++++
 rtl/alu_sequencer_alu.sv | 39 +++
 rtl/alu_sequencer.sv | 166 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_sequencer_pkg
//   Shared constants for the ALU sequencer: datapath widths, instruction-word
//   field positions, ALU op encodings and the sequencer FSM state encodings.
//   No ports (package).
// -----------------------------------------------------------------------------
package alu_sequencer_pkg;

    localparam int DATA_W   = 4;
    localparam int REG_W    = 2;
    localparam int INSTR_W  = 10;
    localparam int NUM_REGS = 4;
    localparam int RET_W    = 8;

    // Instruction word layout
    localparam int LOADI_BIT = 9;
    localparam int OP_MSB    = 8;
    localparam int OP_LSB    = 6;
    localparam int RD_MSB    = 5;
    localparam int RD_LSB    = 4;
    localparam int RS_MSB    = 3;
    localparam int RS_LSB    = 2;
    localparam int RT_MSB    = 1;
    localparam int RT_LSB    = 0;
    localparam int IMM_MSB   = 3;
    localparam int IMM_LSB   = 0;

    typedef enum logic [2:0] {
        OP_SUB = 3'd0,  // A - B
        OP_ADD = 3'd1,  // A + B
        OP_OR  = 3'd2,  // A | B
        OP_AND = 3'd3,  // A & B
        OP_SRA = 3'd4,  // B arithmetic shift right by one
        OP_ROL = 3'd5,  // A rotate left by one
        OP_LTU = 3'd6,  // A < B unsigned
        OP_EQ  = 3'd7   // A == B
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/alu_sequencer_alu.sv
// -----------------------------------------------------------------------------
// Decode_And_Execute
//   Purely combinational 4-bit ALU used by the sequencer's EXEC state.
//   Ports:
//     rs  in  4  first operand (A)
//     rt  in  4  second operand (B)
//     sel in  3  operation select (op_e encoding)
//     rd  out 4  result, modulo 16
// -----------------------------------------------------------------------------
module Decode_And_Execute
    import alu_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    input  logic [2:0]        sel,
    output logic [DATA_W-1:0] rd
);

    // Signed view of B so the shift-right op replicates the sign bit.
    logic signed [DATA_W-1:0] rt_signed;

    assign rt_signed = rt;

    always_comb begin
        rd = '0;
        case (op_e'(sel))
            OP_SUB:  rd = rs - rt;
            OP_ADD:  rd = rs + rt;
            OP_OR:   rd = rs | rt;
            OP_AND:  rd = rs & rt;
            OP_SRA:  rd = DATA_W'(rt_signed >>> 1);
            OP_ROL:  rd = {rs[DATA_W-2:0], rs[DATA_W-1]};
            OP_LTU:  rd = (rs < rt)  ? DATA_W'(1) : '0;
            OP_EQ:   rd = (rs == rt) ? DATA_W'(1) : '0;
            default: rd = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Non-pipelined instruction sequencer around a 4x4-bit register file and a
//   combinational ALU. Each instruction walks IDLE -> DECODE -> (EXEC) -> DONE;
//   LOADI skips EXEC. The result is held in DONE until the consumer accepts it.
//   Ports:
//     clk       in  1   rising-edge clock
//     rst_n     in  1   synchronous active-low reset
//     in_valid  in  1   instruction offered
//     in_ready  out 1   sequencer can accept an instruction (IDLE only)
//     instr     in  10  {loadi, op[2:0], rd[1:0], rs[1:0], rt[1:0]};
//                       for LOADI, [3:0] is the immediate
//     out_valid out 1   result present (DONE only)
//     out_ready in  1   consumer accepts the result
//     out_data  out 4   result value (registered)
//     out_rd    out 2   destination register of the result (registered)
//     retired   out 8   completed-instruction count, wraps at 256
// -----------------------------------------------------------------------------
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [REG_W-1:0]   out_rd,
    output logic [RET_W-1:0]   retired
);

    state_e             state;
    state_e             next_state;

    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  opa;
    logic [DATA_W-1:0]  opb;
    logic [DATA_W-1:0]  result;
    logic [DATA_W-1:0]  alu_out;
    logic [DATA_W-1:0]  rf [NUM_REGS];
    logic [RET_W-1:0]   retire_count;

    // Control strobes decoded from the current state
    logic               accept;
    logic               load_ops;
    logic               write_imm;
    logic               write_alu;
    logic               retire;

    logic [REG_W-1:0]   rd_idx;
    logic [REG_W-1:0]   rs_idx;
    logic [REG_W-1:0]   rt_idx;

    assign rd_idx = ir[RD_MSB:RD_LSB];
    assign rs_idx = ir[RS_MSB:RS_LSB];
    assign rt_idx = ir[RT_MSB:RT_LSB];

    Decode_And_Execute u_alu (
        .rs  (opa),
        .rt  (opb),
        .sel (ir[OP_MSB:OP_LSB]),
        .rd  (alu_out)
    );

    // ---------------------------------------------------------------- FSM state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        load_ops   = 1'b0;
        write_imm  = 1'b0;
        write_alu  = 1'b0;
        retire     = 1'b0;
        case (state)
            ST_IDLE: begin
                // Held low while reset is asserted, even though state is IDLE.
                in_ready = rst_n;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (ir[LOADI_BIT]) begin
                    write_imm  = 1'b1;
                    next_state = ST_DONE;
                end else begin
                    load_ops   = 1'b1;
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                write_alu  = 1'b1;
                next_state = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    retire     = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------- datapath registers
    // Operands are captured in DECODE and the register file is written only
    // in DECODE (LOADI) or EXEC (ALU), so aliased rs/rt/rd always read the old
    // value, and the write lands well before the next instruction's DECODE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir     <= '0;
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (accept) begin
                ir <= instr;
            end
            if (load_ops) begin
                opa <= rf[rs_idx];
                opb <= rf[rt_idx];
            end
            if (write_imm) begin
                result     <= ir[IMM_MSB:IMM_LSB];
                rf[rd_idx] <= ir[IMM_MSB:IMM_LSB];
            end
            if (write_alu) begin
                result     <= alu_out;
                rf[rd_idx] <= alu_out;
            end
        end
    end

    // ------------------------------------------------------- retired counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_count <= '0;
        end else if (retire) begin
            retire_count <= retire_count + RET_W'(1);
        end
    end

    // IR is only reloaded on accept, so out_rd is stable throughout DONE.
    assign out_data = result;
    assign out_rd   = rd_idx;
    assign retired  = retire_count;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] instr;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_rd;
    logic [7:0] retired;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_q [$];   // {rd, data}
    logic [3:0] m_rf [4];
    logic [7:0] m_ret;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .retired   (retired)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [9:0] mk_alu(input logic [2:0] op, input logic [1:0] rd,
                                          input logic [1:0] rs, input logic [1:0] rt);
        return {1'b0, op, rd, rs, rt};
    endfunction

    function automatic logic [9:0] mk_li(input logic [1:0] rd, input logic [3:0] imm);
        return {1'b1, 3'b000, rd, imm};
    endfunction

    function automatic logic [3:0] model_alu(input logic [2:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
        case (op)
            3'd0:    return a - b;
            3'd1:    return a + b;
            3'd2:    return a | b;
            3'd3:    return a & b;
            3'd4:    return {b[3], b[3:1]};
            3'd5:    return {a[2:0], a[3]};
            3'd6:    return (a < b) ? 4'd1 : 4'd0;
            default: return (a == b) ? 4'd1 : 4'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
        m_ret = 8'd0;
        exp_q.delete();
    endtask

    // Called when an instruction is driven for acceptance: predict and queue.
    task automatic push_expected(input logic [9:0] ins);
        logic [3:0] r;
        if (ins[9]) r = ins[3:0];
        else        r = model_alu(ins[8:6], m_rf[ins[3:2]], m_rf[ins[1:0]]);
        m_rf[ins[5:4]] = r;
        exp_q.push_back({ins[5:4], r});
    endtask

    // Issue one instruction and retire it. Starts and ends at a negedge.
    // Latency counts rising edges with the accept edge as the first.
    task automatic do_instr(input logic [9:0] ins, input string name);
        int n;
        int lat;
        logic [5:0] e;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL %s accept: in_ready=%b required 1", name, in_ready);
            errors++;
            return;
        end
        in_valid = 1'b1;
        instr    = ins;
        push_expected(ins);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat != (ins[9] ? 2 : 3) || out_valid !== 1'b1) begin
            $display("FAIL %s latency: edges=%0d out_valid=%b required %0d", name, lat,
                     out_valid, ins[9] ? 2 : 3);
            errors++;
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (out_data !== e[3:0]) begin
            $display("FAIL %s out_data: got %h required %h", name, out_data, e[3:0]);
            errors++;
        end
        checks++;
        if (out_rd !== e[5:4]) begin
            $display("FAIL %s out_rd: got %0d required %0d", name, out_rd, e[5:4]);
            errors++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        m_ret = m_ret + 8'd1;
        checks++;
        if (retired !== m_ret) begin
            $display("FAIL %s retired: got %0d required %0d", name, retired, m_ret);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 10'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL reset in_ready during reset: got %b required 0", in_ready);
            errors++;
        end
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL reset handshake: in_ready=%b out_valid=%b required 1/0",
                     in_ready, out_valid);
            errors++;
        end
        checks++;
        if (out_data !== 4'd0 || out_rd !== 2'd0 || retired !== 8'd0) begin
            $display("FAIL reset outputs: data=%h rd=%0d retired=%0d required 0/0/0",
                     out_data, out_rd, retired);
            errors++;
        end
    endtask

    task automatic test_basic_add();
        do_instr(mk_li(2'd1, 4'd5), "li_r1_5");
        do_instr(mk_li(2'd2, 4'd3), "li_r2_3");
        do_instr(mk_alu(3'd1, 2'd3, 2'd1, 2'd2), "add_r3");
        checks++;
        if (retired !== 8'd3) begin
            $display("FAIL basic retired: got %0d required 3", retired);
            errors++;
        end
    endtask

    task automatic test_compare_ops();
        do_instr(mk_li(2'd1, 4'd3), "li_r1_3");
        do_instr(mk_li(2'd2, 4'd5), "li_r2_5");
        do_instr(mk_alu(3'd0, 2'd0, 2'd1, 2'd2), "sub_wrap");
        do_instr(mk_alu(3'd6, 2'd0, 2'd1, 2'd2), "ltu");
        do_instr(mk_alu(3'd7, 2'd0, 2'd1, 2'd2), "eq_false");
        do_instr(mk_alu(3'd7, 2'd0, 2'd1, 2'd1), "eq_alias");
        do_instr(mk_alu(3'd2, 2'd3, 2'd1, 2'd2), "or");
        do_instr(mk_alu(3'd3, 2'd3, 2'd2, 2'd3), "and_alias");
    endtask

    task automatic test_shift_rotate();
        do_instr(mk_li(2'd1, 4'b1001), "li_r1_9");
        do_instr(mk_alu(3'd4, 2'd0, 2'd0, 2'd1), "sra");
        do_instr(mk_alu(3'd5, 2'd0, 2'd1, 2'd0), "rol");
        do_instr(mk_alu(3'd5, 2'd1, 2'd1, 2'd0), "rol_self_1");
        do_instr(mk_alu(3'd5, 2'd1, 2'd1, 2'd0), "rol_self_2");
        // Read R1 back through OR with itself: must be 4'b0110.
        do_instr(mk_alu(3'd2, 2'd2, 2'd1, 2'd1), "r1_readback");
    endtask

    task automatic wait_and_retire(input string name);
        int n;
        logic [5:0] e;
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            $display("FAIL %s timeout: out_valid=%b required 1", name, out_valid);
            errors++;
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (out_data !== e[3:0] || out_rd !== e[5:4]) begin
            $display("FAIL %s result: got %h/%0d required %h/%0d", name, out_data, out_rd,
                     e[3:0], e[5:4]);
            errors++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        m_ret = m_ret + 8'd1;
        checks++;
        if (retired !== m_ret) begin
            $display("FAIL %s retired: got %0d required %0d", name, retired, m_ret);
            errors++;
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] first;
        logic [9:0] second;
        logic [5:0] e;
        int n;
        do_instr(mk_li(2'd1, 4'd6), "bp_li_r1");
        do_instr(mk_li(2'd2, 4'd7), "bp_li_r2");
        first  = mk_alu(3'd1, 2'd2, 2'd1, 2'd2);  // R2 = 6 + 7 = 13
        second = mk_alu(3'd0, 2'd3, 2'd2, 2'd1);  // R3 = R2 - R1, needs new R2
        in_valid = 1'b1;
        instr    = first;
        push_expected(first);
        @(posedge clk);
        @(negedge clk);
        instr = second;   // in_valid stays high while busy: must be ignored
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        e = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== e[3:0] || out_rd !== e[5:4] ||
                in_ready !== 1'b0 || retired !== m_ret) begin
                $display("FAIL hold cycle %0d: valid=%b data=%h rd=%0d in_ready=%b retired=%0d required 1/%h/%0d/0/%0d",
                         i, out_valid, out_data, out_rd, in_ready, retired, e[3:0], e[5:4], m_ret);
                errors++;
            end
            @(negedge clk);
        end
        wait_and_retire("hold_release");
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL hold next accept: in_ready=%b required 1", in_ready);
            errors++;
        end
        push_expected(second);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL hold second taken: in_ready=%b required 0", in_ready);
            errors++;
        end
        wait_and_retire("raw_after_hold");
    endtask

    task automatic test_back_to_back();
        logic [7:0] start;
        // LOADI stream: one instruction per 3 cycles.
        start     = m_ret;
        instr     = mk_li(2'd0, 4'd7);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        m_ret     = start + 8'd10;
        m_rf[0]   = 4'd7;
        checks++;
        if (retired !== m_ret) begin
            $display("FAIL b2b loadi retired: got %0d required %0d", retired, m_ret);
            errors++;
        end
        // ALU stream: one instruction per 4 cycles.
        start     = m_ret;
        instr     = mk_alu(3'd1, 2'd0, 2'd0, 2'd0);  // R0 doubles each time
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        m_ret     = start + 8'd10;
        // 7 doubled ten times mod 16 is 0 after the fourth doubling.
        m_rf[0]   = 4'd0;
        checks++;
        if (retired !== m_ret || out_data !== 4'd0) begin
            $display("FAIL b2b alu: retired=%0d data=%h required %0d/0", retired, out_data, m_ret);
            errors++;
        end
        do_instr(mk_alu(3'd2, 2'd1, 2'd0, 2'd0), "b2b_r0_readback");
    endtask

    task automatic test_reset_mid_exec();
        int seen;
        do_instr(mk_li(2'd3, 4'd15), "mr_li_r3");
        do_instr(mk_li(2'd1, 4'd5), "mr_li_r1");
        do_instr(mk_li(2'd2, 4'd6), "mr_li_r2");
        in_valid = 1'b1;
        instr    = mk_alu(3'd1, 2'd3, 2'd1, 2'd2);
        @(posedge clk);       // accept
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);       // DECODE -> EXEC
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL midreset in_ready: got %b required 0", in_ready);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || retired !== 8'd0 ||
            out_data !== 4'd0 || out_rd !== 2'd0) begin
            $display("FAIL midreset state: in_ready=%b valid=%b retired=%0d data=%h rd=%0d required 1/0/0/0/0",
                     in_ready, out_valid, retired, out_data, out_rd);
            errors++;
        end
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            $display("FAIL midreset out_valid rose: cycles=%0d required 0", seen);
            errors++;
        end
        do_instr(mk_alu(3'd2, 2'd0, 2'd3, 2'd3), "midreset_r3_zero");
        do_instr(mk_alu(3'd2, 2'd0, 2'd1, 2'd2), "midreset_r1r2_zero");
    endtask

    task automatic test_retired_wrap();
        test_reset();
        for (int i = 0; i < 256; i++) begin
            do_instr(mk_li(2'(i), 4'(i)), "wrap_li");
        end
        checks++;
        if (retired !== 8'd0) begin
            $display("FAIL wrap retired: got %0d required 0", retired);
            errors++;
        end
        do_instr(mk_alu(3'd1, 2'd0, 2'd1, 2'd2), "wrap_alu_latency");
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_compare_ops();
        test_shift_rotate();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_exec();
        test_retired_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
